// File: rtl/avalon_mem_arbiter.sv
// Two-port Avalon-MM master arbiter: an instruction-fetch port and a data read/write port share
// one Avalon-MM master with at most one transaction in flight.
//
// Ports
//   CLK, RST              single clock, synchronous active-high reset
//   i_req/i_addr          fetch request (level) and address
//   i_rdata/i_done        fetched word and one-cycle completion pulse
//   d_rd/d_wr/d_addr/     data read/write request (level), address, write data
//   d_wdata
//   d_rdata/d_done        read data and one-cycle completion pulse
//   err                   pulses with i_done/d_done on timeout or illegal request (d_rd & d_wr)
//   avm_*                 Avalon-MM master (word aligned, all byte lanes enabled)
//   busy                  high whenever the arbiter is not idle
//
// Parameters
//   PRIO     1: data port always wins; 0: round-robin on contention
//   TIMEOUT  cycles allowed in command/wait states before the transfer is aborted (1..65535)
module avalon_mem_arbiter #(
  parameter int unsigned PRIO    = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy
);

  localparam logic [31:0] AddrMask  = 32'hFFFF_FFFC;
  localparam logic [16:0] TimeoutW  = 17'(TIMEOUT);
  localparam logic        FixedPrio = (PRIO != 0);

  typedef enum logic [2:0] {
    StIdle,
    StICmd,
    StIWait,
    StDRd,
    StDRWait,
    StDWr,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_d_q, last_d_d;  // 1: data port was granted last
  logic        ill_q, ill_d;        // current data request had both d_rd and d_wr set
  logic        busy_q;

  logic        d_pend;
  logic        grant_data;
  logic [16:0] cnt_inc;
  logic        timeout_hit;

  assign d_pend = d_rd | d_wr;
  // Round-robin: on contention the data port wins only if fetch was granted last.
  assign grant_data  = d_pend & (FixedPrio | ~i_req | ~last_d_q);
  assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
  // Set in the cycle that would be the TIMEOUT-th one spent in command/wait states.
  assign timeout_hit = (cnt_inc >= TimeoutW);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    ill_d     = ill_q;

    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          addr_d   = d_addr & AddrMask;
          wdata_d  = d_wdata;
          cnt_d    = '0;
          last_d_d = 1'b1;
          ill_d    = d_rd & d_wr;
          if (d_wr) begin
            state_d = StDWr;
            write_d = 1'b1;
          end else begin
            state_d = StDRd;
            read_d  = 1'b1;
          end
        end else if (i_req) begin
          addr_d   = i_addr & AddrMask;
          cnt_d    = '0;
          last_d_d = 1'b0;
          ill_d    = 1'b0;
          state_d  = StICmd;
          read_d   = 1'b1;
        end
      end

      // An accept in the last allowed cycle still leaves the read data outstanding, so the
      // timeout takes precedence over waitrequest here.
      StICmd: begin
        cnt_d = cnt_inc[15:0];
        if (timeout_hit) begin
          read_d    = 1'b0;
          i_rdata_d = '0;
          i_done_d  = 1'b1;
          err_d     = 1'b1;
          state_d   = StDone;
        end else if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = StIWait;
        end
      end

      StIWait: begin
        cnt_d = cnt_inc[15:0];
        if (avm_readdatavalid) begin
          i_rdata_d = avm_readdata;
          i_done_d  = 1'b1;
          state_d   = StDone;
        end else if (timeout_hit) begin
          i_rdata_d = '0;
          i_done_d  = 1'b1;
          err_d     = 1'b1;
          state_d   = StDone;
        end
      end

      StDRd: begin
        cnt_d = cnt_inc[15:0];
        if (timeout_hit) begin
          read_d    = 1'b0;
          d_rdata_d = '0;
          d_done_d  = 1'b1;
          err_d     = 1'b1;
          state_d   = StDone;
        end else if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = StDRWait;
        end
      end

      StDRWait: begin
        cnt_d = cnt_inc[15:0];
        if (avm_readdatavalid) begin
          d_rdata_d = avm_readdata;
          d_done_d  = 1'b1;
          state_d   = StDone;
        end else if (timeout_hit) begin
          d_rdata_d = '0;
          d_done_d  = 1'b1;
          err_d     = 1'b1;
          state_d   = StDone;
        end
      end

      StDWr: begin
        cnt_d = cnt_inc[15:0];
        if (!avm_waitrequest) begin
          write_d  = 1'b0;
          d_done_d = 1'b1;
          err_d    = ill_q;
          state_d  = StDone;
        end else if (timeout_hit) begin
          write_d  = 1'b0;
          d_done_d = 1'b1;
          err_d    = 1'b1;
          state_d  = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      last_d_q  <= 1'b1;
      ill_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      ill_q     <= ill_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign i_rdata        = i_rdata_q;
  assign i_done         = i_done_q;
  assign d_rdata        = d_rdata_q;
  assign d_done         = d_done_q;
  assign err            = err_q;
  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign busy           = busy_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter. Index 0 is a round-robin instance, index 1 a fixed-priority one,
// both with TIMEOUT=8. Expected behaviour of each transfer is derived from the slave timing the
// bench chooses (wait cycles, read latency) and the arbitration rules.
module tb_avalon_mem_arbiter;

  localparam int T = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]       rst, i_req, d_rd, d_wr, i_done, d_done, err;
  logic [1:0]       avm_read, avm_write, waitreq, rdv, busy;
  logic [1:0][31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
  logic [1:0][31:0] avm_address, avm_writedata, rdata;
  logic [1:0][3:0]  byteen;

  avalon_mem_arbiter #(.PRIO(0), .TIMEOUT(T)) u_dut_rr (
    .CLK(CLK), .RST(rst[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_done(i_done[0]),
    .d_rd(d_rd[0]), .d_wr(d_wr[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_done(d_done[0]), .err(err[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_write(avm_write[0]),
    .avm_writedata(avm_writedata[0]), .avm_byteenable(byteen[0]),
    .avm_waitrequest(waitreq[0]), .avm_readdatavalid(rdv[0]), .avm_readdata(rdata[0]),
    .busy(busy[0])
  );

  avalon_mem_arbiter #(.PRIO(1), .TIMEOUT(T)) u_dut_fp (
    .CLK(CLK), .RST(rst[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_done(i_done[1]),
    .d_rd(d_rd[1]), .d_wr(d_wr[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_done(d_done[1]), .err(err[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_write(avm_write[1]),
    .avm_writedata(avm_writedata[1]), .avm_byteenable(byteen[1]),
    .avm_waitrequest(waitreq[1]), .avm_readdatavalid(rdv[1]), .avm_readdata(rdata[1]),
    .busy(busy[1])
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cur_u  = 0;
  bit          last_d[2];     // model: data port granted last
  logic [31:0] m_irdata[2];
  logic [31:0] m_drdata[2];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s (dut %0d): got %b, want %b", tag, cur_u, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s (dut %0d): got %08h, want %08h", tag, cur_u, obs, exp);
    end
  endtask

  task automatic chk_rst(input int u);
    cur_u = u;
    chk1("rst_busy", busy[u], 1'b0);
    chk1("rst_i_done", i_done[u], 1'b0);
    chk1("rst_d_done", d_done[u], 1'b0);
    chk1("rst_err", err[u], 1'b0);
    chk1("rst_read", avm_read[u], 1'b0);
    chk1("rst_write", avm_write[u], 1'b0);
    chk32("rst_addr", avm_address[u], 32'h0);
    chk32("rst_wdata", avm_writedata[u], 32'h0);
    chk32("rst_i_rdata", i_rdata[u], 32'h0);
    chk32("rst_d_rdata", d_rdata[u], 32'h0);
    chk32("byteenable", {28'h0, byteen[u]}, 32'hF);
  endtask

  // Starts in an IDLE cycle (#1 after the edge) with requests already driven. w = waitrequest
  // cycles, l = cycles from accept to readdatavalid (0 = never), rd = read data returned.
  task automatic serve(input int u, input int w, input int l, input logic [31:0] rd);
    bit          pi, pd, gd, is_wr, ill, fin, real_rdv;
    int          total, kd, ncmd;
    logic [31:0] ea, ewd, erd;
    cur_u      = u;
    waitreq[u] = 1'b0;
    rdv[u]     = 1'b0;
    pi = i_req[u];
    pd = d_rd[u] | d_wr[u];
    gd = pd && ((u == 1) || !pi || !last_d[u]);
    last_d[u] = gd;
    is_wr = gd && d_wr[u];
    ill   = gd && d_rd[u] && d_wr[u];
    ea    = (gd ? d_addr[u] : i_addr[u]) & 32'hFFFF_FFFC;
    ewd   = d_wdata[u];
    total = is_wr ? w + 1 : ((l == 0) ? T + 100 : w + 1 + l);
    fin   = (total <= T);
    kd    = (fin ? total : T) + 1;
    ncmd  = (w + 1 < T) ? w + 1 : T;
    erd   = (!is_wr && fin) ? rd : 32'h0;
    for (int k = 1; k <= kd; k++) begin
      @(posedge CLK); #1;
      if (k < kd) begin
        real_rdv   = (l != 0) && (k == w + 1 + l);
        waitreq[u] = (k <= w);
        // Stray readdatavalid while the command is still presented must be ignored.
        rdv[u]     = real_rdv ? 1'b1 : ((k <= w + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        rdata[u]   = real_rdv ? rd : $urandom;
        chk1("busy", busy[u], 1'b1);
        chk1("early_i_done", i_done[u], 1'b0);
        chk1("early_d_done", d_done[u], 1'b0);
        chk1("early_err", err[u], 1'b0);
        chk1("avm_read", avm_read[u], !is_wr && (k <= ncmd));
        chk1("avm_write", avm_write[u], is_wr && (k <= ncmd));
        chk32("avm_address", avm_address[u], ea);
        if (is_wr) chk32("avm_writedata", avm_writedata[u], ewd);
      end else begin
        waitreq[u] = 1'b0;
        rdv[u]     = 1'b0;
        if (gd) begin
          if (!is_wr) m_drdata[u] = erd;
        end else begin
          m_irdata[u] = erd;
        end
        chk1("done_read", avm_read[u], 1'b0);
        chk1("done_write", avm_write[u], 1'b0);
        chk1("done_busy", busy[u], 1'b1);
        chk1("i_done", i_done[u], !gd);
        chk1("d_done", d_done[u], gd);
        chk1("err", err[u], ill || !fin);
        chk32("done_addr", avm_address[u], ea);
        chk32("i_rdata", i_rdata[u], m_irdata[u]);
        chk32("d_rdata", d_rdata[u], m_drdata[u]);
        if (gd) begin
          d_rd[u] = 1'b0;
          d_wr[u] = 1'b0;
        end else begin
          i_req[u] = 1'b0;
        end
      end
    end
    @(posedge CLK); #1;
    chk1("idle_busy", busy[u], 1'b0);
    chk1("idle_i_done", i_done[u], 1'b0);
    chk1("idle_d_done", d_done[u], 1'b0);
    chk1("idle_err", err[u], 1'b0);
    chk32("hold_i_rdata", i_rdata[u], m_irdata[u]);
    chk32("hold_d_rdata", d_rdata[u], m_drdata[u]);
  endtask

  task automatic rand_phase(input int u, input int n);
    int op, w, l;
    for (int t = 0; t < n; t++) begin
      if (!i_req[u] && $urandom_range(0, 1) == 1) begin
        i_req[u]  = 1'b1;
        i_addr[u] = $urandom;
      end
      if (!(d_rd[u] | d_wr[u]) && ($urandom_range(0, 1) == 1 || !i_req[u])) begin
        op         = $urandom_range(0, 9);
        d_rd[u]    = (op < 5);
        d_wr[u]    = (op == 0) || (op >= 5);
        d_addr[u]  = $urandom;
        d_wdata[u] = $urandom;
      end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      serve(u, w, l, $urandom);
    end
  endtask

  initial begin
    rst = 2'b11; i_req = '0; d_rd = '0; d_wr = '0; waitreq = '0; rdv = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; rdata = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst = 2'b00;
    for (int u = 0; u < 2; u++) begin
      last_d[u] = 1'b1; m_irdata[u] = 32'h0; m_drdata[u] = 32'h0;
      chk_rst(u);
    end

    // No requests: stay idle with no bus command.
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      for (int u = 0; u < 2; u++) begin
        cur_u = u;
        chk1("noreq_busy", busy[u], 1'b0);
        chk1("noreq_read", avm_read[u], 1'b0);
      end
    end

    // Zero-wait fetch: done in the third cycle after the request.
    i_req[1] = 1'b1; i_addr[1] = 32'h100;
    serve(1, 0, 1, 32'h0050_0093);

    // Fixed priority: data read first, then the waiting fetch.
    i_req[1] = 1'b1; i_addr[1] = 32'h204;
    d_rd[1]  = 1'b1; d_addr[1] = 32'h2000;
    serve(1, 0, 1, 32'h1111_2222);
    serve(1, 1, 2, 32'h3333_4444);

    // Write stalled by three waitrequest cycles.
    d_wr[1] = 1'b1; d_addr[1] = 32'h3004; d_wdata[1] = 32'hCAFE_F00D;
    serve(1, 3, 1, 32'h0);

    // Read that never returns data: timeout abort.
    d_rd[1] = 1'b1; d_addr[1] = 32'h40;
    serve(1, 0, 0, 32'h0);

    // Read and write together: write performed, flagged as error.
    d_rd[1] = 1'b1; d_wr[1] = 1'b1; d_addr[1] = 32'h7; d_wdata[1] = 32'h1234_5678;
    serve(1, 1, 1, 32'h0);

    // Round-robin with both ports always requesting: I, D, I, D.
    for (int t = 0; t < 4; t++) begin
      if (!i_req[0]) begin i_req[0] = 1'b1; i_addr[0] = 32'h1000 + 32'(t); end
      if (!d_rd[0]) begin d_rd[0] = 1'b1; d_addr[0] = 32'h8000 + 32'(t); end
      serve(0, t % 2, 1, 32'hA000_0000 + 32'(t));
    end
    i_req[0] = 1'b0; d_rd[0] = 1'b0;
    // Data was granted last, so the next contention would go to fetch again.
    i_req[0] = 1'b1; i_addr[0] = 32'h2220; d_rd[0] = 1'b1; d_addr[0] = 32'h3330;
    serve(0, 0, 1, 32'h5555_0000);
    serve(0, 0, 1, 32'h6666_0000);

    // Reset while waiting for fetch data; the late readdatavalid must be ignored.
    cur_u = 0;
    i_req[0] = 1'b1; i_addr[0] = 32'h104;
    @(posedge CLK); #1;
    waitreq[0] = 1'b0;
    chk1("pre_rst_read", avm_read[0], 1'b1);
    @(posedge CLK); #1;
    chk1("pre_rst_busy", busy[0], 1'b1);
    chk1("pre_rst_rd_off", avm_read[0], 1'b0);
    rst[0] = 1'b1; i_req[0] = 1'b0;
    @(posedge CLK); #1;
    rst[0] = 1'b0; rdv[0] = 1'b1; rdata[0] = 32'hDEAD_BEEF;
    last_d[0] = 1'b1; m_irdata[0] = 32'h0; m_drdata[0] = 32'h0;
    chk_rst(0);
    @(posedge CLK); #1;
    rdv[0] = 1'b0;
    chk_rst(0);

    rand_phase(0, 40);
    rand_phase(1, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avalon_mem_arbiter.md
AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

Interface
REQ-001 Parameter PRIO, default 1: 1 = data port has fixed priority; 0 = round-robin between ports.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles in any command/wait state before abort; range 1..65535.
REQ-003 CLK  in  1  single clock, all logic on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  instruction fetch request, level, held until i_done sampled high.
REQ-006 i_addr  in  32  fetch address, stable while i_req high.
REQ-007 i_rdata  out  32  fetched word, valid while i_done high.
REQ-008 i_done  out  1  one-cycle completion pulse for the fetch port.
REQ-009 d_rd / d_wr  in  1 each  data read / write request, level, held until d_done sampled high.
REQ-010 d_addr, d_wdata  in  32 each  data address and write data, stable while request high.
REQ-011 d_rdata  out  32  read data, valid while d_done high.
REQ-012 d_done  out  1  one-cycle completion pulse for the data port.
REQ-013 err  out  1  one-cycle pulse with i_done/d_done when the transfer was aborted or illegal.
REQ-014 avm_address  out  32; avm_read, avm_write  out  1; avm_writedata  out  32; avm_byteenable  out  4.
REQ-015 avm_waitrequest, avm_readdatavalid  in  1; avm_readdata  in  32.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, ICMD, IWAIT, DRD, DRWAIT, DWR, DONE; all outputs driven from registers.
REQ-018 IDLE: pending requests sampled; no pending -> stay IDLE, all avm command outputs 0.
REQ-019 Grant, PRIO=1: any data request wins over i_req.
REQ-020 Grant, PRIO=0: both pending -> port not granted last; single pending -> that port; last-grant flag resets to "data", so first contention grants fetch.
REQ-021 On grant, address and write data latched into avm_address/avm_writedata; held constant until DONE.
REQ-022 d_rd and d_wr both high: write performed, read ignored, err pulsed with d_done.
REQ-023 avm_byteenable = 4'hF always; avm_address low two bits forced to 00.
REQ-024 ICMD/DRD: avm_read=1; stays until cycle with avm_waitrequest=0, then -> IWAIT/DRWAIT with avm_read=0 from next cycle.
REQ-025 DWR: avm_write=1; stays until avm_waitrequest=0, then -> DONE.
REQ-026 IWAIT/DRWAIT: on avm_readdatavalid=1 capture avm_readdata into i_rdata/d_rdata, -> DONE.
REQ-027 avm_readdatavalid in any other state ignored; no outstanding transaction ever exceeds one.
REQ-028 DONE: exactly one of i_done/d_done high for one cycle, then -> IDLE; requests not sampled in DONE.
REQ-029 Requester deasserts request at the clock edge where done is sampled; arbiter re-arbitrates in following IDLE.
REQ-030 Timeout counter clears on every grant, increments each cycle in ICMD/IWAIT/DRD/DRWAIT/DWR.
REQ-031 Counter reaching TIMEOUT: command outputs dropped, read data forced to 32'h0, -> DONE with err=1.
REQ-032 Latency, zero-wait fetch with readdatavalid next cycle: req in IDLE cycle 0 -> ICMD 1 -> IWAIT 2 -> i_done cycle 3.
REQ-033 Latency, zero-wait write: d_wr in IDLE cycle 0 -> DWR 1 -> d_done cycle 2.
REQ-034 i_rdata/d_rdata hold last captured value outside done cycles.

Reset
REQ-035 RST=1 at a rising edge: state IDLE, avm_read/avm_write/i_done/d_done/err/busy = 0, avm_address/avm_writedata/i_rdata/d_rdata = 32'h0, counter 0, last-grant = data.
REQ-036 Reset mid-transaction aborts silently (no done pulse); late avm_readdatavalid after reset ignored.

Verification
REQ-037 i_req, i_addr=32'h100, waitrequest=0, readdata=32'h00500093 one cycle after accept -> i_done cycle 3, i_rdata=32'h00500093.
REQ-038 PRIO=1, i_req and d_rd same cycle, d_addr=32'h2000 -> avm_address=32'h2000 first; fetch issued after d_done.
REQ-039 PRIO=0, both ports continuously requesting for 4 transfers -> grants alternate I,D,I,D.
REQ-040 d_wr, d_addr=32'h3004, d_wdata=32'hCAFEF00D, waitrequest high 3 cycles -> avm_write high 4 cycles, data stable, d_done one cycle after accept.
REQ-041 TIMEOUT=8, d_rd, readdatavalid never asserted -> d_done and err pulse, d_rdata=32'h0, then IDLE.
REQ-042 RST asserted in IWAIT, readdatavalid arrives next cycle -> no i_done, all outputs at reset values.
